// File: rtl/hazard_unit_if.sv
// Pipeline-side signal bundle of the hazard unit: Decode/Execute register fields in, forward/stall/flush controls out.
// The perf counters exist only when HAZARD_PERF_EN is defined.
interface hazard_unit_if;
    logic [4:0]  rs1_D;
    logic [4:0]  rs2_D;
    logic [4:0]  rd_E;
    logic        reg_wr_E;
    logic [1:0]  wb_sel_E;
    logic        br_taken;
    logic        for_A;
    logic        for_B;
    logic        stall_F;
    logic        stall_D;
    logic        flush_D;
    logic        flush_E;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    // Pipeline side: drives register fields, consumes hazard controls.
    modport master (
        output rs1_D, rs2_D, rd_E, reg_wr_E, wb_sel_E, br_taken,
`ifdef HAZARD_PERF_EN
        input  stall_cnt, flush_cnt,
`endif
        input  for_A, for_B, stall_F, stall_D, flush_D, flush_E
    );

    // Hazard unit side.
    modport slave (
        input  rs1_D, rs2_D, rd_E, reg_wr_E, wb_sel_E, br_taken,
`ifdef HAZARD_PERF_EN
        output stall_cnt, flush_cnt,
`endif
        output for_A, for_B, stall_F, stall_D, flush_D, flush_E
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard unit for a 3-stage pipeline: ALU-result forwarding, one-cycle load-use stall, branch flush.
// Optional saturating stall/flush performance counters are built when HAZARD_PERF_EN is defined.
module hazard_unit (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t state_r;

    logic match_a_s;
    logic match_b_s;
    logic alu_src_s;
    logic hazard_s;
    logic stall_go_s;
    logic for_a_s;
    logic for_b_s;
    logic stall_s;
    logic flush_d_s;
    logic flush_e_s;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic reg_match(
        input logic       wr,
        input logic [4:0] rd,
        input logic [4:0] rs
    );
        reg_match = wr & (rd != 5'd0) & (rd == rs);
    endfunction

    // Dependency detection against the instruction in Execute.
    always_comb begin
        match_a_s = reg_match(bus.reg_wr_E, bus.rd_E, bus.rs1_D);
        match_b_s = reg_match(bus.reg_wr_E, bus.rd_E, bus.rs2_D);
        alu_src_s = (bus.wb_sel_E == 2'b00);
        hazard_s  = (match_a_s | match_b_s) & ~alu_src_s;
    end

    // Control outputs from inputs and FSM state; a taken branch overrides any stall.
    always_comb begin
        for_a_s    = 1'b0;
        for_b_s    = 1'b0;
        stall_s    = 1'b0;
        stall_go_s = 1'b0;
        flush_d_s  = 1'b0;
        flush_e_s  = 1'b0;
        if (rst) begin
            for_a_s    = 1'b0;
            for_b_s    = 1'b0;
            stall_s    = 1'b0;
            stall_go_s = 1'b0;
            flush_d_s  = 1'b0;
            flush_e_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    for_a_s    = match_a_s & alu_src_s;
                    for_b_s    = match_b_s & alu_src_s;
                    stall_go_s = hazard_s & ~bus.br_taken;
                    stall_s    = stall_go_s;
                    flush_d_s  = bus.br_taken;
                    flush_e_s  = bus.br_taken | stall_go_s;
                end
                STALL: begin
                    // The producer has written back; the regfile now holds the value.
                    for_a_s    = 1'b0;
                    for_b_s    = 1'b0;
                    stall_go_s = 1'b0;
                    stall_s    = 1'b0;
                    flush_d_s  = bus.br_taken;
                    flush_e_s  = bus.br_taken;
                end
                default: begin
                    for_a_s    = 1'b0;
                    for_b_s    = 1'b0;
                    stall_go_s = 1'b0;
                    stall_s    = 1'b0;
                    flush_d_s  = 1'b0;
                    flush_e_s  = 1'b0;
                end
            endcase
        end
    end

    assign bus.for_A   = for_a_s;
    assign bus.for_B   = for_b_s;
    assign bus.stall_F = stall_s;
    assign bus.stall_D = stall_s;
    assign bus.flush_D = flush_d_s;
    assign bus.flush_E = flush_e_s;

    // Stall FSM: at most one bubble per hazard, then back to IDLE unconditionally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE:    state_r <= stall_go_s ? STALL : IDLE;
                STALL:   state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    // Saturating event counters for load-use stalls and branch flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
            flush_cnt_r <= 16'h0000;
        end else begin
            if (stall_go_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (bus.br_taken && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'h0001;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
    assign bus.flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed table-driven bench for hazard_unit; counter checks are active when HAZARD_PERF_EN is defined.
module tb_hazard_unit;

    logic clk;
    logic rst;
    hazard_unit_if hif ();

    hazard_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wr;
        logic [1:0]  wb;
        logic        br;
        logic [5:0]  exp;   // {for_A, for_B, stall_F, stall_D, flush_D, flush_E}
        logic [15:0] exp_sc;
        logic [15:0] exp_fc;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(string n, logic r, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic wr, logic [1:0] wb, logic br,
                                logic [5:0] exp, logic [15:0] sc, logic [15:0] fc);
        vec_t v;
        v.name = n; v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.wr = wr;
        v.wb = wb; v.br = br; v.exp = exp; v.exp_sc = sc; v.exp_fc = fc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst          = v.rst;
        hif.rs1_D    = v.rs1;
        hif.rs2_D    = v.rs2;
        hif.rd_E     = v.rd;
        hif.reg_wr_E = v.wr;
        hif.wb_sel_E = v.wb;
        hif.br_taken = v.br;
    endtask

    task automatic check6(input string n, input logic [5:0] exp);
        logic [5:0] act;
        act = {hif.for_A, hif.for_B, hif.stall_F, hif.stall_D, hif.flush_D, hif.flush_E};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %b expected %b", n, act, exp);
        end
    endtask

    task automatic check16(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    initial begin
        // Rows run back to back; counter columns give the value seen during that row.
        vecs[0]  = mk("reset_hold",      1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 2'b01, 1'b1, 6'b000000, 16'd0, 16'd0);
        vecs[1]  = mk("fwd_a",           1'b0, 5'd5, 5'd7, 5'd5, 1'b1, 2'b00, 1'b0, 6'b100000, 16'd0, 16'd0);
        vecs[2]  = mk("fwd_b",           1'b0, 5'd1, 5'd9, 5'd9, 1'b1, 2'b00, 1'b0, 6'b010000, 16'd0, 16'd0);
        vecs[3]  = mk("fwd_both",        1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 2'b00, 1'b0, 6'b110000, 16'd0, 16'd0);
        vecs[4]  = mk("no_wr",           1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 2'b00, 1'b0, 6'b000000, 16'd0, 16'd0);
        vecs[5]  = mk("rd0_load",        1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0, 6'b000000, 16'd0, 16'd0);
        vecs[6]  = mk("rd0_alu",         1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 2'b00, 1'b0, 6'b000000, 16'd0, 16'd0);
        vecs[7]  = mk("load_use",        1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 2'b01, 1'b0, 6'b001101, 16'd0, 16'd0);
        vecs[8]  = mk("stall_cycle",     1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 2'b01, 1'b0, 6'b000000, 16'd1, 16'd0);
        vecs[9]  = mk("back_idle_fwd",   1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 2'b00, 1'b0, 6'b010000, 16'd1, 16'd0);
        vecs[10] = mk("pc4_hazard",      1'b0, 5'd1, 5'd2, 5'd1, 1'b1, 2'b10, 1'b0, 6'b001101, 16'd1, 16'd0);
        vecs[11] = mk("br_in_stall",     1'b0, 5'd1, 5'd2, 5'd1, 1'b1, 2'b10, 1'b1, 6'b000011, 16'd2, 16'd0);
        vecs[12] = mk("load_use_br",     1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 2'b01, 1'b1, 6'b000011, 16'd2, 16'd1);
        vecs[13] = mk("after_br_idle",   1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 2'b01, 1'b0, 6'b001101, 16'd2, 16'd2);
        vecs[14] = mk("rsvd_in_stall",   1'b0, 5'd5, 5'd2, 5'd5, 1'b1, 2'b11, 1'b0, 6'b000000, 16'd3, 16'd2);
        vecs[15] = mk("rsvd_hazard",     1'b0, 5'd5, 5'd2, 5'd5, 1'b1, 2'b11, 1'b0, 6'b001101, 16'd3, 16'd2);
        vecs[16] = mk("rst_in_stall",    1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 2'b11, 1'b0, 6'b000000, 16'd4, 16'd2);
        vecs[17] = mk("post_rst_idle",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 6'b000000, 16'd0, 16'd0);
        vecs[18] = mk("post_rst_hazard", 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0, 6'b001101, 16'd0, 16'd0);
        vecs[19] = mk("bubble_stall",    1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 2'b01, 1'b0, 6'b000000, 16'd1, 16'd0);
        vecs[20] = mk("fwd_with_br",     1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 2'b00, 1'b1, 6'b100011, 16'd1, 16'd0);

        drive(vecs[0]);
        repeat (2) @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            check6(vecs[i].name, vecs[i].exp);
`ifdef HAZARD_PERF_EN
            check16({vecs[i].name, "_stall_cnt"}, hif.stall_cnt, vecs[i].exp_sc);
            check16({vecs[i].name, "_flush_cnt"}, hif.flush_cnt, vecs[i].exp_fc);
`endif
        end

        // Back-to-back load-use hazards: each gets exactly one stall cycle.
        @(posedge clk); #1;
        drive(mk("b2b", 1'b0, 5'd4, 5'd0, 5'd4, 1'b1, 2'b01, 1'b0, 6'b0, 16'd0, 16'd0));
        @(negedge clk); check6("b2b_first", 6'b001101);
        @(posedge clk); #1;
        @(negedge clk); check6("b2b_stall", 6'b000000);
        @(posedge clk); #1;
        @(negedge clk); check6("b2b_second", 6'b001101);

`ifdef HAZARD_PERF_EN
        // Flush counter saturation over 65,537 branch cycles.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        drive(mk("sat", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 6'b0, 16'd0, 16'd0));
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check16("flush_cnt_fffe", hif.flush_cnt, 16'hFFFE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check16("flush_cnt_sat", hif.flush_cnt, 16'hFFFF);
        check16("stall_cnt_sat_run", hif.stall_cnt, 16'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port rs1_D  input  5  source register 1 of the instruction in Decode.
REQ-004 SHALL have port rs2_D  input  5  source register 2 of the instruction in Decode.
REQ-005 SHALL have port rd_E  input  5  destination register of the instruction in Execute/Writeback.
REQ-006 SHALL have port reg_wr_E  input  1  the Execute instruction writes rd_E.
REQ-007 SHALL have port wb_sel_E  input  2  writeback source of the Execute instruction: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-008 SHALL have port br_taken  input  1  a branch or jump in Execute redirects the PC this cycle.
REQ-009 SHALL have port for_A  output  1  operand-A forward select: 1 selects Alu_out_E, 0 selects rdata1.
REQ-010 SHALL have port for_B  output  1  operand-B forward select, same encoding as for_A.
REQ-011 SHALL have port stall_F  output  1  hold the PC.
REQ-012 SHALL have port stall_D  output  1  hold the Fetch/Decode register.
REQ-013 SHALL have port flush_D  output  1  clear the Fetch/Decode register to a NOP.
REQ-014 SHALL have port flush_E  output  1  insert a bubble into the Decode/Execute register.
REQ-015 SHALL have port stall_cnt  output  16  saturating count of load-use stall cycles; present only with HAZARD_PERF_EN.
REQ-016 SHALL have port flush_cnt  output  16  saturating count of branch flushes; present only with HAZARD_PERF_EN.

Function
REQ-017 SHALL define match_A = reg_wr_E & (rd_E != 0) & (rd_E == rs1_D); match_B is the same with rs2_D.
REQ-018 SHALL drive for_A = match_A & (wb_sel_E == 00), combinationally in the same cycle; for_B is the same with match_B.
REQ-019 SHALL define hazard = (match_A | match_B) & (wb_sel_E != 00), covering load results, PC+4 link values and the reserved encoding.
REQ-020 SHALL implement a 2-state FSM, IDLE and STALL, with IDLE as the reset state.
REQ-021 IDLE: when hazard & !br_taken, SHALL assert stall_F, stall_D and flush_E in the same cycle and move to STALL at the next edge.
REQ-022 STALL: SHALL suppress hazard detection, drive for_A = for_B = 0 so the regfile supplies the written-back value, and return to IDLE unconditionally at the next edge.
REQ-023 SHALL limit consecutive stall cycles to exactly 1 per hazard.
REQ-024 br_taken SHALL assert flush_D and flush_E in the same cycle, in either FSM state.
REQ-025 br_taken SHALL take priority over hazard: stall_F and stall_D stay 0, and the FSM stays in or returns to IDLE.
REQ-026 rd_E == 0 SHALL never produce a forward or a stall.
REQ-027 When match_A and match_B are both true, SHALL assert both for_A and for_B, and count a stall only once.
REQ-028 Outputs other than the counters SHALL be combinational from the inputs and the FSM state, with 0 latency.

Reset
REQ-029 While rst = 1, SHALL hold the FSM in IDLE and drive for_A, for_B, stall_F, stall_D, flush_D and flush_E to 0, regardless of other inputs.
REQ-030 Reset asserted in the STALL state SHALL return the FSM to IDLE at that edge, with no residual stall.
REQ-031 Reset SHALL clear stall_cnt and flush_cnt to 0.

Configuration
REQ-032 With macro HAZARD_PERF_EN defined, SHALL include stall_cnt, incremented on each IDLE-to-STALL transition, and flush_cnt, incremented on each cycle with br_taken = 1.
REQ-033 Both counters SHALL saturate at 16'hFFFF.
REQ-034 Without HAZARD_PERF_EN, the counter ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 SHALL cover: rd_E=5, reg_wr_E=1, wb_sel_E=00, rs1_D=5, rs2_D=7 -> for_A=1, for_B=0, no stall.
REQ-036 SHALL cover: rd_E=5, wb_sel_E=01, rs2_D=5 -> stall_F=stall_D=flush_E=1 for exactly 1 cycle, FSM goes to STALL and then IDLE, for_B=0 in the STALL cycle, stall_cnt=1.
REQ-037 SHALL cover: rd_E=0, reg_wr_E=1, rs1_D=0, rs2_D=0, wb_sel_E=01 -> all outputs 0.
REQ-038 SHALL cover: load-use hazard together with br_taken=1 -> flush_D=flush_E=1, stall_F=0, FSM stays IDLE, flush_cnt=1, stall_cnt=0.
REQ-039 SHALL cover: rst=1 asserted in the STALL cycle -> next cycle all outputs 0, FSM IDLE, counters 0.
REQ-040 SHALL cover, with HAZARD_PERF_EN: 65,537 br_taken cycles -> flush_cnt=16'hFFFF.
